// File: rtl/reg_bus_arbiter_if.sv
// Request/grant and register-control bundle for reg_bus_arbiter.
// Master is the requester side; slave is the arbiter.
interface reg_bus_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] rw;
  logic [N-1:0] reg_en;
  logic [N-1:0] reg_oe;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         busy;

  modport master (
    output req, rw,
    input  reg_en, reg_oe, gnt, done, busy
  );

  modport slave (
    input  req, rw,
    output reg_en, reg_oe, gnt, done, busy
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin sequencer for N tri-state registers on one bus.
// One transfer at a time, with a turnaround cycle after each.
module reg_bus_arbiter #(
  parameter int N       = 4,
  parameter int RD_HOLD = 2
) (
  input logic             clk,
  input logic             rst_n,
  reg_bus_arbiter_if.slave bus
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(RD_HOLD) + 1;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TURN
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            hit;
  logic [SW-1:0]   win;
  int              idx;
  logic [N-1:0]    sel_oh;
  logic            in_xfer;
  logic            last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // first requester at or after ptr, wrapping
  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!hit && bus.req[idx]) begin
        hit = 1'b1;
        win = SW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          sel_d   = win;
          op_d    = bus.rw[win];
          cnt_d   = bus.rw[win] ? '0
                                : CW'(RD_HOLD - 1);
          state_d = XFER;
        end
      end
      XFER: begin
        if (op_q || cnt_q == '0)
          state_d = TURN;
        else
          cnt_d = cnt_q - 1'b1;
      end
      TURN: begin
        ptr_d   = (int'(sel_q) == N - 1) ? '0
                                         : sel_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs decode only from state/sel/op/cnt flops
  assign sel_oh  = {{(N-1){1'b0}}, 1'b1} << sel_q;
  assign in_xfer = (state_q == XFER);
  assign last    = op_q || (cnt_q == '0);

  assign bus.gnt    = in_xfer ? sel_oh : '0;
  assign bus.reg_en = (in_xfer && op_q) ? sel_oh : '0;
  assign bus.reg_oe = (in_xfer && !op_q) ? sel_oh : '0;
  assign bus.done   = (in_xfer && last) ? sel_oh : '0;
  assign bus.busy   = (state_q != IDLE);
endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
Round-robin arbiter/sequencer for N 4-bit registers with tri-state outputs sharing one bus. Each register has a write enable (EN) and a tri-state output enable (OE). Requesters ask for a write or a read of their own register. The block grants one requester at a time and drives that register's EN or OE. It guarantees that at most one OE is ever active and inserts a turnaround cycle between transfers, so bus drivers never overlap.

Parameters:
N, 4, number of requesters/registers (2..8)
RD_HOLD, 2, cycles OE is held per read transfer (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
req  input  N  per-requester transfer request, level, held until done
rw  input  N  per-requester op: 1 = write (load bus into register), 0 = read (drive register onto bus)
reg_en  output  N  per-register write enable (to register EN)
reg_oe  output  N  per-register output enable (to register OE)
gnt  output  N  one-hot grant, high for the whole transfer
done  output  N  one-cycle pulse on the last transfer cycle
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, ptr=0, sel=0, counter=0. reg_en, reg_oe, gnt, done all 0; busy=0. Effect is immediate, including mid-transfer, so every tri-state output releases the bus at once.
- All outputs are registered (driven from state/sel/op flops). No combinational path from req/rw to outputs.
- States: IDLE, XFER, TURN.
- IDLE:
  - If any req bit is high, search indices ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (modulo N). The first index i with req[i]=1 wins.
  - Latch sel=i and op=rw[i]. Load counter = 0 for a write, RD_HOLD-1 for a read. Go to XFER.
  - If no req bit is high, stay in IDLE.
- XFER:
  - gnt[sel]=1 throughout.
  - Write: reg_en[sel]=1 for exactly 1 cycle; the register captures at the rising edge ending that cycle. done[sel]=1 in the same cycle.
  - Read: reg_oe[sel]=1 for exactly RD_HOLD cycles. Counter decrements each cycle. done[sel]=1 in the cycle where counter==0.
  - After the last cycle, go to TURN.
- TURN: all reg_en/reg_oe/gnt/done = 0; busy=1. Update ptr = (sel+1) mod N. Go to IDLE.
- Latency: req high in IDLE at edge k means gnt and EN/OE are high from cycle k+1.
  - Write: 3 cycles per transfer (XFER, TURN, IDLE sample).
  - Read: RD_HOLD+2 cycles per transfer.
- Latched request: op and sel are fixed once in XFER. A change of req[sel] or rw[sel] during XFER is ignored and the transfer completes.
- Requester contract: drop req in the cycle after done. A req still high in IDLE is a new request, arbitrated fairly through ptr.
- Simultaneous requests: one grant only; the others wait. Round-robin guarantees each pending requester is served within N transfers.
- Invariants:
  - popcount(reg_oe | reg_en) <= 1 and popcount(gnt) <= 1 in every cycle.
  - reg_oe is never high in IDLE or TURN.
  - Any two OE pulses from different transfers are separated by at least 1 cycle with all OE low.
- Counter width = clog2(RD_HOLD)+1; it never wraps.

Test Plan:
- Reset: hold rst_n=0 with random req/rw -> all outputs 0 and busy=0. Assert rst_n=0 asynchronously mid-read (reg_oe[2]=1) -> reg_oe=0 before the next clk edge; after release, state is IDLE and ptr=0.
- Single write: req=0010, rw=0010 at edge 0 -> cycle 1: gnt=0010, reg_en=0010, done=0010; cycle 2: all 0, busy=1; cycle 3: busy=0. The attached register holds the bus value 4'hA driven in cycle 1.
- Single read, RD_HOLD=2: req=1000, rw=0000 -> reg_oe=1000 for cycles 1-2, done=1000 in cycle 2 only, reg_oe=0000 in cycle 3. Bus reads the register value in cycles 1-2 and Z in cycle 3.
- Contention: req=1111 held after each done, mixed rw -> grant order 0,1,2,3,0. A TURN cycle with all OE/EN low follows every transfer, and at most one reg_oe bit is ever high.
- Wrap and fairness: ptr=3 (after serving 2), req=1001 -> requester 3 is granted first, then 0. With req=0001 held continuously and requester 2 raising its req, requester 2 is served before requester 0's second grant.
- Request drop: read for index 1 in progress, drop req[1] and toggle rw[1] in cycle 1 -> reg_oe=0010 still held RD_HOLD cycles, done pulses, no write occurs.
